// File: rtl/div16_seq.sv
// Iterative unsigned restoring divider: one quotient bit per cycle via trial
// subtraction (S + ~divisor + 1), with the carry-out acting as the not-borrow flag.
module div16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;

  logic             accept;
  logic             last;
  logic [WIDTH:0]   s;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic             unused_sum_msb;

  assign accept = start && (state != RUN);
  assign last   = (count == CW'(WIDTH - 1));

  // Shift-in and trial subtraction in WIDTH+1 bits; bit WIDTH+1 is the carry-out.
  assign s         = {r, q[WIDTH-1]};
  assign sum       = {1'b0, s} + {1'b0, ~{1'b0, dvs}} + (WIDTH+2)'(1);
  assign no_borrow = sum[WIDTH+1];
  // A restored remainder is always below the divisor, so bit WIDTH is zero.
  assign r_step    = no_borrow ? sum[WIDTH-1:0] : s[WIDTH-1:0];
  assign q_step    = {q[WIDTH-2:0], no_borrow};
  assign unused_sum_msb = sum[WIDTH];

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:  if (last) state_next = DONE;
      DONE: begin
        if (start) state_next = (divisor == '0) ? DONE : RUN;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      r         <= '0;
      q         <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_err   <= 1'b0;
    end else if (accept && (divisor != '0)) begin
      count <= '0;
      r     <= '0;
      q     <= dividend;
      dvs   <= divisor;
    end else if (accept) begin
      quotient  <= '1;
      remainder <= dividend;
      div_err   <= 1'b1;
    end else if (state == RUN) begin
      r     <= r_step;
      q     <= q_step;
      count <= count + CW'(1);
      if (last) begin
        quotient  <= q_step;
        remainder <= r_step;
        div_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div16_seq.sv
// Directed bench for div16_seq: hand-computed quotients/remainders, latency,
// busy/done timing, ignored starts, back-to-back accepts and async reset.
module tb_div16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_err;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] prev_q = 16'h0;
  logic [15:0] prev_r = 16'h0;
  logic        prev_e = 1'b0;

  div16_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_err   (div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts one operation from an IDLE or DONE cycle and follows it to its done cycle.
  // pulse: fire ignored 7/7 starts at cycles E+3 and E+10.
  // keep : hold start high with next operands 50/6 through the run and DONE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic ee,
                        input int lat, input bit pulse, input bit keep);
    int cyc;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      check("busy_run", busy, 1);
      if (cyc == 8) begin
        check("held_q", quotient, prev_q);
        check("held_r", remainder, prev_r);
        check("held_err", div_err, prev_e);
      end
      if (keep) begin
        start = 1'b1; dividend = 16'd50; divisor = 16'd6;
      end else if (pulse && (cyc == 3 || cyc == 10)) begin
        start = 1'b1; dividend = 16'd7; divisor = 16'd7;
      end else begin
        start = 1'b0;
        dividend = 16'($urandom_range(0, 65535));
        divisor  = 16'($urandom_range(0, 65535));
      end
      step();
      cyc++;
    end
    if (!keep) start = 1'b0;
    check("latency", cyc, lat);
    check("done", done, 1);
    check("busy_at_done", busy, 0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_err", div_err, ee);
    prev_q = eq;
    prev_r = er;
    prev_e = ee;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 16'h0;
    divisor  = 16'h0;
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_err", div_err, 0);
    rst_n = 1'b1;

    run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 0, 0);
    step();
    check("done_one_cycle", done, 0);
    run_op(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17, 0, 0);
    step();
    run_op(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 17, 0, 0);
    step();
    run_op(16'h8000, 16'hC000, 16'h0000, 16'h8000, 1'b0, 17, 0, 0);
    step();

    // Divide by zero finishes on the edge after accept, busy never set.
    run_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, 0, 0);
    step();
    check("div0_done_drop", done, 0);
    run_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17, 0, 0);
    step();

    run_op(16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 17, 1, 0);
    step();

    // Back-to-back: start held high through DONE re-accepts on DONE's closing edge.
    run_op(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17, 0, 1);
    run_op(16'd50, 16'd6, 16'd8, 16'd2, 1'b0, 17, 0, 0);
    step();
    check("b2b_done_drop", done, 0);

    // Asynchronous reset in the middle of cycle E+8.
    start    = 1'b1;
    dividend = 16'd1234;
    divisor  = 16'd5;
    step();
    start = 1'b0;
    repeat (7) step();
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    check("arst_err", div_err, 0);
    repeat (20) begin
      step();
      check("arst_no_done", done, 0);
    end
    rst_n  = 1'b1;
    prev_q = 16'h0;
    prev_r = 16'h0;
    prev_e = 1'b0;
    run_op(16'd1234, 16'd5, 16'd246, 16'd4, 1'b0, 17, 0, 0);
    step();
    check("final_idle", busy | done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
